// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the Gray<->binary converter pair.
// Functions work on GW-bit words; callers zero-extend narrower data and truncate the result.
package gray_pkg;

    localparam int GW        = 32;
    localparam int DEF_CNT_W = 8;
    localparam int ERR_MAX   = 2**DEF_CNT_W - 1;

    // Zero-extension is harmless: leading zeros leave the low bits of the prefix XOR unchanged.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b = '0;
        b[GW-1] = g[GW-1];
        for (int i = GW-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcnt(input logic [GW-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < GW; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Tracks the last accepted Gray word and flags an input that is not a single-bit step from it.
module gray_step_chk
    import gray_pkg::*;
#(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] gray,
    input  logic            acc,
    output logic            err
);

    logic [size-1:0] prev_gray;
    logic            have_prev;

    // A repeated word (distance 0) counts as an error just like a multi-bit jump.
    assign err = have_prev & (popcnt(GW'(gray ^ prev_gray)) != 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= '0;
            have_prev <= 1'b0;
        end else if (acc) begin
            prev_gray <= gray;
            have_prev <= 1'b1;
        end
    end

endmodule

// File: rtl/gray_bin_decoder.sv
// Two-stage registered Gray-to-binary decoder with valid/ready flow control,
// per-word step-error flag and a saturating error counter.
module gray_bin_decoder
    import gray_pkg::*;
#(
    parameter int size  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [size-1:0]  gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [size-1:0]  bin_out,
    output logic             step_err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] SAT = '1;

    logic            v1, v2;
    logic            adv1, adv2;
    logic            acc_in, xfer;
    logic            err1;
    logic [size-1:0] s1_gray;
    logic            s1_err;

    // Stall chain: each stage moves when it is empty or the stage after it moves.
    assign adv2     = ~v2 | out_ready;
    assign adv1     = ~v1 | adv2;
    assign in_ready = adv1;
    assign acc_in   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign out_valid = v2;

    gray_step_chk #(.size(size)) u_chk (
        .clk  (clk),
        .rst  (rst),
        .gray (gray_in),
        .acc  (acc_in),
        .err  (err1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_gray <= '0;
            s1_err  <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_gray <= gray_in;
                s1_err  <= err1;
            end
        end
    end

    // Decode happens on the S1->S2 move so the output is purely registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2       <= 1'b0;
            bin_out  <= '0;
            step_err <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                bin_out  <= size'(gray2bin(GW'(s1_gray)));
                step_err <= s1_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (xfer && step_err && err_cnt != SAT) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gray_bin_decoder.sv
// Self-checking bench: directed scenarios plus a random phase, all scored against a queue model.
module tb_gray_bin_decoder;

    localparam int SIZE = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [SIZE-1:0] gray_in;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] bin_out;
    logic            step_err;
    logic            out_valid;
    logic            out_ready;
    logic            err_clr;
    logic [CW-1:0]   err_cnt;

    always #5 clk = ~clk;

    gray_bin_decoder #(.size(SIZE), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .step_err  (step_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic [3:0] bin;
        logic       err;
    } sb_t;

    sb_t        q[$];
    logic [3:0] m_prev;
    logic       m_have;
    int         m_cnt;
    logic       last_acc;
    int         checks = 0;
    int         errors = 0;

    // Binary value whose Gray image equals g, found by search rather than XOR chain.
    function automatic logic [3:0] ref_bin(input logic [3:0] g);
        for (int v = 0; v < 16; v++) begin
            if (4'(v ^ (v >> 1)) == g) return 4'(v);
        end
        return 4'hx;
    endfunction

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample before posedge, update model, check counter at next negedge.
    task automatic cyc(input logic [3:0] g, input logic iv, input logic ordy,
                       input logic clr, input logic r);
        sb_t  e;
        logic acc, xfer;
        gray_in   = g;
        in_valid  = iv;
        out_ready = ordy;
        err_clr   = clr;
        rst       = r;
        #1;
        acc  = iv & in_ready;
        xfer = out_valid & out_ready;
        e = '{bin: 4'd0, err: 1'b0};
        if (!r && xfer) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("bin_out", 32'(bin_out), 32'(e.bin));
                chk("step_err", 32'(step_err), 32'(e.err));
            end
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            m_have = 1'b0;
            m_prev = 4'd0;
            m_cnt  = 0;
        end else begin
            if (clr) m_cnt = 0;
            else if (xfer && e.err && m_cnt < CMAX) m_cnt++;
            if (acc) begin
                q.push_back('{bin: ref_bin(g), err: m_have && ($countones(g ^ m_prev) != 1)});
                m_prev = g;
                m_have = 1'b1;
            end
        end
        last_acc = acc;
        @(negedge clk);
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            cyc(4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_idle", 32'(out_valid), 32'd0);
    endtask

    logic [3:0] rb;

    initial begin
        rst = 1'b1; gray_in = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        m_prev = '0; m_have = 1'b0; m_cnt = 0; last_acc = 1'b0;
        @(negedge clk);

        // 1. reset with in_valid held high
        repeat (3) cyc(4'h5, 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 2. full stream 0..15 then wrap to 0
        for (int i = 0; i <= 16; i++) begin
            cyc(to_gray(4'(i)), 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 0) chk("lat_first_edge", 32'(out_valid), 32'd0);
            if (i == 1) begin
                chk("lat_second_edge", 32'(out_valid), 32'd1);
                chk("lat_first_bin", 32'(bin_out), 32'd0);
            end
        end
        drain();
        chk("stream_err_cnt", 32'(err_cnt), 32'd0);

        // 3. backpressure
        cyc(4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) begin
            cyc(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_bin_hold", 32'(bin_out), 32'd0);
        end
        cyc(4'b0011, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // 4. step errors: distance 2, then repeat
        cyc(4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        chk("step_err_cnt", 32'(err_cnt), 32'd2);

        // 5. saturation, then clear beating an erroneous transfer
        repeat (5) cyc(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        chk("sat_err_cnt", 32'(err_cnt), 32'd3);
        cyc(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_word_err", 32'(step_err), 32'd1);
        cyc(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("clr_priority", 32'(err_cnt), 32'd0);

        // 6. reset with both stages full
        cyc(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_full", 32'(out_valid), 32'd1);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        cyc(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_first_valid", 32'(out_valid), 32'd1);
        chk("mid_first_bin", 32'(bin_out), 32'd4);
        chk("mid_first_err", 32'(step_err), 32'd0);
        drain();

        // random phase: mostly +1 walks, some -1 and jumps, random handshakes and clears
        rb = 4'd4;
        for (int i = 0; i < 400; i++) begin
            cyc(to_gray(rb), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 150) == 0));
            if (last_acc) begin
                case ($urandom_range(0, 9))
                    7:       rb = rb - 4'd1;
                    8, 9:    rb = 4'($urandom_range(0, 15));
                    default: rb = rb + 4'd1;
                endcase
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
